deagg_arbiter: RTL and testbench

- Shares one narrow receiver path (the async write FIFO feeding the ANN datapath) between NUM_SENDERS wide-word sender FIFOs.
- Grants senders round-robin, one whole wide word per grant.
- Deaggregates each latched word into FETCH_WIDTH narrow beats, slice 0 first, and tags every beat with its source index.
- Sits between the sender FIFOs and the receiver FIFO, in place of a dedicated per-sender deaggregator.

---
 rtl/deagg_arbiter.sv | 141 ++++++++++++++
 tb/tb_deagg_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deagg_arbiter.sv
// deagg_arbiter: round-robin share of one narrow receiver FIFO between
// NUM_SENDERS wide-word sender FIFOs. Each grant pops one whole word, which is
// replayed as FETCH_WIDTH narrow beats (slice 0 first), each tagged with the
// index of the sender it came from.
//
// Handshakes: a sender offers a word while sender_empty_n[s]=1 and loses it
// on the clock edge that ends a cycle in which sender_deq[s]=1. The receiver
// takes a beat on every edge that ends a cycle in which receiver_enq=1. That
// is exactly the SEND cycles with receiver_full_n=1. While receiver_full_n=0,
// the offered beat (data, src, last) is held unchanged.
module deagg_arbiter #(
   parameter  int DATA_WIDTH  = 11,
   parameter  int FETCH_WIDTH = 4,
   parameter  int NUM_SENDERS = 2,
   localparam int SRC_W       = (NUM_SENDERS > 1) ? $clog2(NUM_SENDERS) : 1
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        enable,
   input  logic [NUM_SENDERS*FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
   input  logic [NUM_SENDERS-1:0]                      sender_empty_n,
   output logic [NUM_SENDERS-1:0]                      sender_deq,
   output logic [DATA_WIDTH-1:0]                       receiver_data,
   output logic [SRC_W-1:0]                            receiver_src,
   output logic                                        receiver_last,
   input  logic                                        receiver_full_n,
   output logic                                        receiver_enq,
   output logic                                        busy
);

   localparam int WORD_W = FETCH_WIDTH * DATA_WIDTH;
   localparam int IDX_W  = $clog2(FETCH_WIDTH);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] r_word;
   logic [SRC_W-1:0]  r_src;
   logic [SRC_W-1:0]  r_last_grant;

   logic              w_found;
   logic [SRC_W-1:0]  w_gnt;
   logic [WORD_W-1:0] w_sel_word;
   logic [DATA_WIDTH-1:0] w_data;
   logic              w_last;
   logic              w_enq;
   logic              w_boundary;
   logic              w_grant;

   // Round-robin pick: first pass looks above last_grant, second pass wraps to
   // the lowest index, which together give the order last_grant+1, +2, ...
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      for (int s = 0; s < NUM_SENDERS; s++) begin
         if (!w_found && sender_empty_n[s] && (SRC_W'(s) > r_last_grant)) begin
            w_found = 1'b1;
            w_gnt   = SRC_W'(s);
         end
      end
      for (int s = 0; s < NUM_SENDERS; s++) begin
         if (!w_found && sender_empty_n[s]) begin
            w_found = 1'b1;
            w_gnt   = SRC_W'(s);
         end
      end
   end

   // Select the winning sender's wide word for loading into the word register.
   always_comb begin
      w_sel_word = '0;
      for (int s = 0; s < NUM_SENDERS; s++) begin
         if (w_gnt == SRC_W'(s)) begin
            w_sel_word = sender_data[s*WORD_W +: WORD_W];
         end
      end
   end

   // Beat mux: slice idx of the latched word.
   always_comb begin
      w_data = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_data = r_word[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A word boundary is either an idle cycle or the accepted last beat; a grant
   // there lets the next word follow with no bubble.
   always_comb begin
      w_last     = (r_state == S_SEND) && (r_idx == IDX_W'(FETCH_WIDTH - 1));
      w_enq      = (r_state == S_SEND) && receiver_full_n;
      w_boundary = (r_state == S_IDLE) || (w_enq && w_last);
      w_grant    = w_boundary && enable && w_found;
   end

   // One-hot pop of the granted sender; held low while reset is asserted.
   always_comb begin
      sender_deq = '0;
      for (int s = 0; s < NUM_SENDERS; s++) begin
         sender_deq[s] = w_grant && !rst && (w_gnt == SRC_W'(s));
      end
   end

   // Control FSM: latches a word on grant, steps the beat index on each accepted
   // beat, and drops to IDLE after the last beat when no grant follows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_word       <= '0;
         r_src        <= '0;
         r_last_grant <= SRC_W'(NUM_SENDERS - 1);
      end else if (w_grant) begin
         r_state      <= S_SEND;
         r_idx        <= '0;
         r_word       <= w_sel_word;
         r_src        <= w_gnt;
         r_last_grant <= w_gnt;
      end else if (w_enq) begin
         if (w_last) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
         end else begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   assign receiver_data = w_data;
   assign receiver_src  = r_src;
   assign receiver_last = w_last;
   assign receiver_enq  = w_enq;
   assign busy          = (r_state == S_SEND);

endmodule

// File: tb/tb_deagg_arbiter.sv
// tb_deagg_arbiter: directed tests for deagg_arbiter with two queue-backed
// sender models, a scoreboard of expected beats and a negedge monitor.
module tb_deagg_arbiter;

   localparam int DW = 11;
   localparam int FW = 4;
   localparam int NS = 2;
   localparam int SW = 1;
   localparam int WW = FW * DW;
   localparam int EW = SW + 1 + DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic receiver_full_n = 1'b1;
   logic [NS*WW-1:0] sender_data;
   logic [NS-1:0]    sender_empty_n;
   logic [NS-1:0]    sender_deq;
   logic [DW-1:0]    receiver_data;
   logic [SW-1:0]    receiver_src;
   logic             receiver_last;
   logic             receiver_enq;
   logic             busy;

   always #5 clk = ~clk;

   deagg_arbiter #(
      .DATA_WIDTH (DW),
      .FETCH_WIDTH(FW),
      .NUM_SENDERS(NS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .sender_data    (sender_data),
      .sender_empty_n (sender_empty_n),
      .sender_deq     (sender_deq),
      .receiver_data  (receiver_data),
      .receiver_src   (receiver_src),
      .receiver_last  (receiver_last),
      .receiver_full_n(receiver_full_n),
      .receiver_enq   (receiver_enq),
      .busy           (busy)
   );

   // ---------------- bench state ----------------
   logic [WW-1:0] sq0[$];
   logic [WW-1:0] sq1[$];
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int enq_cnt  = 0;
   int deq_cnt  = 0;
   int deq1_cnt = 0;
   int first_enq = -1;
   int last_enq  = -1;
   int deq_cyc[$];
   logic [NS-1:0] deq_seen = '0;
   logic          prev_stall = 1'b0;
   logic [EW-1:0] prev_out;
   logic [EW-1:0] cur;
   logic [EW-1:0] e;

   function automatic logic [WW-1:0] mk_word(input int base);
      logic [WW-1:0] w;
      w = '0;
      for (int i = 0; i < FW; i++) w[i*DW +: DW] = DW'(base + i);
      return w;
   endfunction

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
   endtask

   // Expected beats of one word: slice i carries base+i, last on slice FW-1.
   task automatic push_word(input int base, input int src);
      for (int i = 0; i < FW; i++)
         exp_q.push_back({SW'(src), 1'(i == FW - 1), DW'(base + i)});
   endtask

   // ---------------- sender models ----------------
   // Pops follow the deq seen at the previous negedge; inputs change only at
   // posedge+#1 (tests) and posedge+#2 (this model).
   initial begin
      sender_data    = '0;
      sender_empty_n = '0;
      forever begin
         @(posedge clk);
         #2;
         if (deq_seen[0] && sq0.size() != 0) void'(sq0.pop_front());
         if (deq_seen[1] && sq1.size() != 0) void'(sq1.pop_front());
         sender_data[0 +: WW]  = (sq0.size() != 0) ? sq0[0] : '0;
         sender_data[WW +: WW] = (sq1.size() != 0) ? sq1[0] : '0;
         sender_empty_n = {sq1.size() != 0, sq0.size() != 0};
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_stall = 1'b0;
         deq_seen   = '0;
      end else begin
         deq_seen = sender_deq;
         if (sender_deq != '0) begin
            deq_cnt++;
            if (sender_deq[1]) deq1_cnt++;
            deq_cyc.push_back(cyc);
            check("deq_onehot", int'($onehot(sender_deq)), 1);
         end
         cur = {receiver_src, receiver_last, receiver_data};
         if (prev_stall) check("stall_stable", int'(cur), int'(prev_out));
         if (receiver_enq) begin
            enq_cnt++;
            if (first_enq < 0) first_enq = cyc;
            last_enq = cyc;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL beat: got unexpected beat %h, expected none", cur);
            end else begin
               e = exp_q.pop_front();
               check("beat", int'(cur), int'(e));
            end
         end
         prev_stall = busy && !receiver_full_n;
         prev_out   = cur;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      check("rst_deq",  int'(sender_deq), 0);
      check("rst_enq",  int'(receiver_enq), 0);
      check("rst_data", int'(receiver_data), 0);
      check("rst_src",  int'(receiver_src), 0);
      check("rst_last", int'(receiver_last), 0);
      check("rst_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      enq_cnt = 0; deq_cnt = 0; deq1_cnt = 0;
      deq_cyc.delete();
      first_enq = -1; last_enq = -1;
   endtask

   task automatic wait_drain(input bit rnd, input int budget);
      int  k;
      bit  done;
      k = 0; done = 1'b0;
      while (!done && k < budget) begin
         @(posedge clk); #1;
         if (rnd) receiver_full_n = 1'($urandom_range(0, 1));
         @(negedge clk); #1;
         done = (exp_q.size() == 0) && !busy;
         k++;
      end
      receiver_full_n = 1'b1;
      if (!done) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d beats outstanding after %0d cycles, expected 0",
                  exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic load_pair();
      sq0.push_back(mk_word(0));   sq0.push_back(mk_word(4));
      sq1.push_back(mk_word(100)); sq1.push_back(mk_word(104));
      push_word(0, 0); push_word(100, 1); push_word(4, 0); push_word(104, 1);
   endtask

   // ---------------- tests ----------------
   initial begin
      int k;
      int d0;
      do_reset();

      // T1: single sender, two words back to back
      enable = 1'b1;
      sq0.push_back(mk_word(0)); sq0.push_back(mk_word(4));
      push_word(0, 0); push_word(4, 0);
      wait_drain(1'b0, 50);
      check("t1_deq_count", deq_cyc.size(), 2);
      if (deq_cyc.size() == 2) check("t1_deq_spacing", deq_cyc[1] - deq_cyc[0], 4);
      check("t1_beat_span", last_enq - first_enq, 7);
      check("t1_enq_ratio", enq_cnt, 4 * deq_cnt);

      // T2: both senders busy, strict alternation without bubbles
      do_reset();
      load_pair();
      wait_drain(1'b0, 80);
      check("t2_deq_count", deq_cnt, 4);
      check("t2_beat_span", last_enq - first_enq, 15);
      check("t2_enq_ratio", enq_cnt, 4 * deq_cnt);

      // T3: same traffic under random backpressure
      do_reset();
      load_pair();
      wait_drain(1'b1, 400);
      check("t3_deq_count", deq_cnt, 4);
      check("t3_enq_ratio", enq_cnt, 4 * deq_cnt);

      // T4: enable drops during beat 1; word completes, then idle
      do_reset();
      sq0.push_back(mk_word(200)); sq1.push_back(mk_word(300));
      push_word(200, 0);
      k = 0;
      do begin @(negedge clk); k++; end while (!busy && k < 20);
      check("t4_started", int'(busy), 1);
      @(posedge clk); #1;
      enable = 1'b0;
      wait_drain(1'b0, 40);
      d0 = deq_cnt;
      repeat (6) @(negedge clk);
      check("t4_no_deq_disabled", deq_cnt - d0, 0);
      check("t4_idle_disabled", int'(busy), 0);
      @(posedge clk); #1;
      enable = 1'b1;
      push_word(300, 1);
      wait_drain(1'b0, 40);
      check("t4_enq_ratio", enq_cnt, 4 * deq_cnt);

      // T5: reset during beat 1 of an S1 word
      do_reset();
      sq1.push_back(mk_word(400));
      push_word(400, 0);
      void'(exp_q.pop_back()); void'(exp_q.pop_back());
      void'(exp_q.pop_back()); void'(exp_q.pop_back());
      exp_q.push_back({1'b1, 1'b0, DW'(400)});
      k = 0;
      do begin @(negedge clk); k++; end while (!sender_deq[1] && k < 20);
      check("t5_s1_grant", int'(sender_deq[1]), 1);
      @(posedge clk); #1;
      sq0.push_back(mk_word(500)); sq1.push_back(mk_word(404));
      do_reset();
      push_word(500, 0); push_word(404, 1);
      wait_drain(1'b0, 60);
      check("t5_deq_count", deq_cnt, 2);
      check("t5_enq_ratio", enq_cnt, 4 * deq_cnt);

      // T6: S1 streams alone, S0 joins mid-stream and they alternate
      do_reset();
      sq1.push_back(mk_word(600)); sq1.push_back(mk_word(604));
      sq1.push_back(mk_word(608)); sq1.push_back(mk_word(612));
      push_word(600, 1); push_word(604, 1);
      k = 0;
      do begin @(negedge clk); #1; k++; end while (deq1_cnt < 2 && k < 30);
      check("t6_s1_two_grants", deq1_cnt, 2);
      @(posedge clk); #1;
      sq0.push_back(mk_word(700)); sq0.push_back(mk_word(704));
      push_word(700, 0); push_word(608, 1); push_word(704, 0); push_word(612, 1);
      wait_drain(1'b0, 100);
      check("t6_beat_span", last_enq - first_enq, 23);
      check("t6_enq_ratio", enq_cnt, 4 * deq_cnt);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish");
      $fatal(1);
   end

endmodule
